// File: rtl/flt_pkg.sv
// Shared single-precision constants and the divider sequencing states.
// Also intended for reuse by flt_mult.
package flt_pkg;

  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;
  localparam int FLT_BIAS  = 127;
  localparam logic [31:0] FLT_QNAN = 32'h7FC0_0000;
  localparam int DIV_ITER  = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } div_state_e;

endpackage

// File: rtl/flt_div_if.sv
// Start/busy/done handshake bundle between a requester and flt_div.
interface flt_div_if;
  logic        start;
  logic [31:0] afl;
  logic [31:0] bfl;
  logic        busy;
  logic        done;
  logic [31:0] fl;

  modport master (output start, afl, bfl, input busy, done, fl);
  modport slave  (input start, afl, bfl, output busy, done, fl);
endinterface

// File: rtl/flt_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, q = floor(ma*2^25/mb).
module flt_mant_div (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [23:0] ma_i,
  input  logic [23:0] mb_i,
  output logic [25:0] q_o
);

  logic [24:0] rem_q, rem_d;
  logic [23:0] mb_q, mb_d;
  logic [25:0] quo_q, quo_d;
  logic [23:0] diff;
  logic        ge;

  // After a successful subtract the remainder is below mb, so 24 bits suffice.
  assign ge   = (rem_q >= {1'b0, mb_q});
  assign diff = rem_q[23:0] - mb_q;

  always_comb begin
    rem_d = rem_q;
    mb_d  = mb_q;
    quo_d = quo_q;
    if (load_i) begin
      rem_d = {1'b0, ma_i};
      mb_d  = mb_i;
      quo_d = '0;
    end else if (step_i) begin
      rem_d = ge ? {diff, 1'b0} : {rem_q[23:0], 1'b0};
      quo_d = {quo_q[24:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q <= '0;
      mb_q  <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      mb_q  <= mb_d;
      quo_q <= quo_d;
    end
  end

  assign q_o = quo_q;

endmodule

// File: rtl/flt_div.sv
// Iterative single-precision divider (fl = afl / bfl), fixed 27-cycle latency.
module flt_div
  import flt_pkg::*;
#(
  parameter bit SIGNED_ZERO = 1'b0
) (
  input logic       clk,
  input logic       rstn,
  flt_div_if.slave  bus
);

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] a_q, a_d, b_q, b_d, fl_q, fl_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        load, step;
  logic [25:0] q;

  logic                 sign, a_zero, b_zero;
  logic [FLT_EXP_W-1:0] e_diff, e_norm;
  logic [24:0]          m_rnd;
  logic [31:0]          res;

  flt_mant_div u_mant (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .step_i (step),
    .ma_i   ({1'b1, bus.afl[22:0]}),
    .mb_i   ({1'b1, bus.bfl[22:0]}),
    .q_o    (q)
  );

  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_zero = (a_q[30:0] == '0);
    b_zero = (b_q[30:0] == '0);
    e_diff = a_q[30:23] - b_q[30:23];
    if (q[25]) begin
      m_rnd  = {1'b0, q[25:2]} + {24'd0, q[1]};
      e_norm = e_diff + 8'(FLT_BIAS);
    end else begin
      m_rnd  = {1'b0, q[24:1]} + {24'd0, q[0]};
      e_norm = e_diff + 8'(FLT_BIAS - 1);
    end
    // A rounding carry leaves the fraction bits at zero; only the exponent bumps.
    e_norm = e_norm + {7'd0, m_rnd[24]};
    if (a_zero && b_zero)
      res = FLT_QNAN;
    else if (a_zero)
      res = SIGNED_ZERO ? {sign, 31'd0} : 32'd0;
    else if (b_zero)
      res = {sign, 8'hFF, 23'd0};
    else
      res = {sign, e_norm, m_rnd[FLT_MAN_W-1:0]};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    fl_d    = fl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.afl;
          b_d     = bus.bfl;
          count_d = '0;
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        step = 1'b1;
        if (count_q == 5'(DIV_ITER - 1))
          state_d = NORM;
        else
          count_d = count_q + 5'd1;
      end
      NORM: begin
        fl_d    = res;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fl_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fl_q    <= fl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.fl   = fl_q;

endmodule
